// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the AES SIMD core: captures the memory-stage
// results, selects the register-file write value and counts retirements.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [DATA_W-1:0]     MemData,
    input  logic [DATA_W-1:0]     SBoxData,
    input  logic [DATA_W-1:0]     rconData,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [2:0]            ResultSrcM,
    output logic [DATA_W-1:0]     WBData,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  RegWriteW,
    output logic                  ValidW,
    output logic [DATA_W-1:0]     FwdData,
    output logic [CNT_W-1:0]      RetireCount
);

    // Handshake: in_valid marks a real instruction in the memory stage. The
    // stage accepts it on any edge with stall=0 and flush=0; stall=1 holds the
    // current occupant; flush=1 replaces the occupant with a bubble. The
    // occupant retires on any edge where ValidW=1 and it is not held.

    typedef enum logic [2:0] {
        SRC_ALU     = 3'b000,
        SRC_MEM     = 3'b001,
        SRC_SBOX    = 3'b010,
        SRC_RCON    = 3'b011,
        SRC_GTERM   = 3'b100,
        SRC_ROTWORD = 3'b101,
        SRC_RSVD6   = 3'b110,
        SRC_RSVD7   = 3'b111
    } result_src_e;

    logic [DATA_W-1:0]     alu_q;
    logic [DATA_W-1:0]     mem_q;
    logic [DATA_W-1:0]     sbox_q;
    logic [DATA_W-1:0]     rcon_q;
    logic [REG_ADDR_W-1:0] wreg_q;
    result_src_e           src_q;
    logic                  valid_q;
    logic                  regwrite_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  load;
    logic                  retire;
    logic [DATA_W-1:0]     wb_sel;

    assign load = ~flush & ~stall;

    // A flushed occupant still leaves the stage, even when stall is also set.
    assign retire = valid_q & (~stall | flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q  <= '0;
            mem_q  <= '0;
            sbox_q <= '0;
            rcon_q <= '0;
            wreg_q <= '0;
            src_q  <= SRC_ALU;
        end else if (load) begin
            alu_q  <= ALUResult;
            mem_q  <= MemData;
            sbox_q <= SBoxData;
            rcon_q <= rconData;
            wreg_q <= WriteRegM;
            src_q  <= result_src_e'(ResultSrcM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= in_valid;
            regwrite_q <= RegWriteM & in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        wb_sel = alu_q;
        case (src_q)
            SRC_ALU:     wb_sel = alu_q;
            SRC_MEM:     wb_sel = mem_q;
            SRC_SBOX:    wb_sel = sbox_q;
            SRC_RCON:    wb_sel = rcon_q;
            SRC_GTERM:   wb_sel = sbox_q ^ rcon_q;
            SRC_ROTWORD: wb_sel = {mem_q[7:0], mem_q[DATA_W-1:8]};
            SRC_RSVD6:   wb_sel = alu_q;
            SRC_RSVD7:   wb_sel = alu_q;
            default:     wb_sel = alu_q;
        endcase
    end

    assign WBData      = wb_sel;
    assign FwdData     = wb_sel;
    assign WriteRegW   = wreg_q;
    assign RegWriteW   = regwrite_q;
    assign ValidW      = valid_q;
    assign RetireCount = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic against a transaction-level model of the stage.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid, RegWriteM;
    logic [31:0] ALUResult, MemData, SBoxData, rconData;
    logic [3:0]  WriteRegM;
    logic [2:0]  ResultSrcM;

    logic [31:0] WBData, FwdData, RetireCount;
    logic [3:0]  WriteRegW;
    logic        RegWriteW, ValidW;

    logic [31:0] WBData4, FwdData4;
    logic [3:0]  WriteRegW4, RetireCount4;
    logic        RegWriteW4, ValidW4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .ALUResult(ALUResult), .MemData(MemData), .SBoxData(SBoxData), .rconData(rconData),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .ResultSrcM(ResultSrcM),
        .WBData(WBData), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .ValidW(ValidW),
        .FwdData(FwdData), .RetireCount(RetireCount)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .ALUResult(ALUResult), .MemData(MemData), .SBoxData(SBoxData), .rconData(rconData),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .ResultSrcM(ResultSrcM),
        .WBData(WBData4), .WriteRegW(WriteRegW4), .RegWriteW(RegWriteW4), .ValidW(ValidW4),
        .FwdData(FwdData4), .RetireCount(RetireCount4)
    );

    // Model: the stage holds one instruction; it stores the already-selected
    // writeback value. Data is unknown after a flush bubble.
    logic        m_valid, m_rw, m_known;
    logic [3:0]  m_wreg;
    logic [31:0] m_wb, m_cnt;

    function automatic logic [31:0] wb_of(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] m, input logic [31:0] sb,
                                          input logic [31:0] rc);
        if (s == 3'd1) return m;
        if (s == 3'd2) return sb;
        if (s == 3'd3) return rc;
        if (s == 3'd4) return sb ^ rc;
        if (s == 3'd5) return (m >> 8) | (m << 24);
        return a;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_known <= 1'b1;
            m_wreg  <= '0;   m_wb <= '0;   m_cnt   <= '0;
        end else begin
            if (m_valid && (!stall || flush)) m_cnt <= m_cnt + 1;
            if (flush) begin
                m_valid <= 1'b0; m_rw <= 1'b0; m_known <= 1'b0;
            end else if (!stall) begin
                m_valid <= in_valid;
                m_rw    <= in_valid && RegWriteM;
                m_wreg  <= WriteRegM;
                m_wb    <= wb_of(ResultSrcM, ALUResult, MemData, SBoxData, rconData);
                m_known <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model ValidW", {31'd0, ValidW}, {31'd0, m_valid});
        chk("model RegWriteW", {31'd0, RegWriteW}, {31'd0, m_rw});
        chk("model RetireCount", RetireCount, m_cnt);
        chk("model RetireCount4", {28'd0, RetireCount4}, {28'd0, m_cnt[3:0]});
        if (m_known) begin
            chk("model WBData", WBData, m_wb);
            chk("model FwdData", FwdData, m_wb);
            chk("model WriteRegW", {28'd0, WriteRegW}, {28'd0, m_wreg});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [3:0] wr,
                         input logic [2:0] src, input logic [31:0] a);
        in_valid = v; RegWriteM = rw; WriteRegM = wr; ResultSrcM = src; ALUResult = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] sweep_exp [5];

    initial begin
        sweep_exp[0] = 32'hA1B2C3D4; sweep_exp[1] = 32'h7C7C7C7C;
        sweep_exp[2] = 32'h00000001; sweep_exp[3] = 32'h7C7C7C7D;
        sweep_exp[4] = 32'hD4A1B2C3;

        // 1. Reset with nonzero inputs, then one load.
        stall = 0; flush = 0;
        MemData = 32'h11112222; SBoxData = 32'h33334444; rconData = 32'h55556666;
        drive(1'b1, 1'b1, 4'hF, 3'd1, 32'hFFFF_FFFF);
        rst = 1'b1;
        #2;
        @(negedge clk);
        chk("reset WBData", WBData, 32'h0);
        chk("reset FwdData", FwdData, 32'h0);
        chk("reset ValidW", {31'd0, ValidW}, 32'h0);
        chk("reset RegWriteW", {31'd0, RegWriteW}, 32'h0);
        chk("reset WriteRegW", {28'd0, WriteRegW}, 32'h0);
        chk("reset RetireCount", RetireCount, 32'h0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'h5, 3'd0, 32'h0000_1234);
        tick();
        chk("load WBData", WBData, 32'h0000_1234);
        chk("load RegWriteW", {31'd0, RegWriteW}, 32'h1);
        chk("load WriteRegW", {28'd0, WriteRegW}, 32'h5);
        chk("load ValidW", {31'd0, ValidW}, 32'h1);
        chk("load RetireCount", RetireCount, 32'h0);

        // 2. Source-select sweep 001..101.
        ALUResult = 32'h1; MemData = 32'hA1B2C3D4; SBoxData = 32'h7C7C7C7C; rconData = 32'h1;
        for (int i = 0; i < 5; i++) begin
            ResultSrcM = 3'(i + 1);
            tick();
            chk($sformatf("sweep src%0d", i + 1), WBData, sweep_exp[i]);
        end
        chk("sweep RetireCount", RetireCount, 32'd5);

        // 3. Stall holds contents and the counter.
        drive(1'b1, 1'b1, 4'h3, 3'd0, 32'hDEADBEEF);
        tick();
        chk("stall load WBData", WBData, 32'hDEADBEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'(i), 3'(i), $urandom);
            MemData = $urandom;
            tick();
            chk("stall WBData", WBData, 32'hDEADBEEF);
            chk("stall RetireCount", RetireCount, 32'd6);
        end
        stall = 1'b0;

        // 4. Flush alone, then flush with stall.
        flush = 1'b1;
        drive(1'b1, 1'b1, 4'h9, 3'd0, 32'h0BADF00D);
        tick();
        chk("flush ValidW", {31'd0, ValidW}, 32'h0);
        chk("flush RegWriteW", {31'd0, RegWriteW}, 32'h0);
        chk("flush RetireCount", RetireCount, 32'd7);
        flush = 1'b0;
        drive(1'b1, 1'b1, 4'hA, 3'd0, 32'h00C0FFEE);
        tick();
        chk("bubble leaves RetireCount", RetireCount, 32'd7);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("stall+flush ValidW", {31'd0, ValidW}, 32'h0);
        chk("stall+flush RegWriteW", {31'd0, RegWriteW}, 32'h0);
        chk("stall+flush RetireCount", RetireCount, 32'd8);
        stall = 1'b0; flush = 1'b0;

        // in_valid=0 with RegWriteM=1 must not write.
        drive(1'b0, 1'b1, 4'h2, 3'd0, 32'h12);
        tick();
        chk("invalid RegWriteW", {31'd0, RegWriteW}, 32'h0);

        // 5. Retire counter: 10 in a row, then 17 for the 4-bit counter.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 4'(i), 3'd0, 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        tick();
        chk("ten retired", RetireCount, 32'd10);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 4'h1, 3'd0, 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        tick();
        chk("seventeen retired", RetireCount, 32'd17);
        chk("4-bit wrap", {28'd0, RetireCount4}, 32'd1);

        // 6. Asynchronous reset mid-stall.
        drive(1'b1, 1'b1, 4'h7, 3'd2, 32'h0);
        SBoxData = 32'hCAFEF00D;
        tick();
        stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst WBData", WBData, 32'h0);
        chk("async rst ValidW", {31'd0, ValidW}, 32'h0);
        chk("async rst RegWriteW", {31'd0, RegWriteW}, 32'h0);
        chk("async rst RetireCount", RetireCount, 32'h0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;

        // Randomized traffic with rare resets.
        for (int n = 0; n < 3000; n++) begin
            stall     = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 10);
            in_valid  = ($urandom_range(0, 99) < 70);
            RegWriteM = $urandom_range(0, 1);
            WriteRegM = 4'($urandom_range(0, 15));
            ResultSrcM = 3'($urandom_range(0, 7));
            ALUResult = $urandom; MemData = $urandom;
            SBoxData  = $urandom; rconData = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
